// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS registers, byte FIFO, bit serialiser (parity bit with UART_TX_PARITY_EN).
// Latency: rdata 1 cycle after a read; a TXDATA write into an idle, empty block drives the start bit 2 edges later.
// Backpressure: none on the bus; a write to a full FIFO is dropped and sets sticky overflow, software polls STATUS.
module uart_tx_mmio #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic        we,
    input  logic        re,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] STOP   = 3'd4;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic       PAR_BUILD = 1'b1;
`else
    localparam logic       PAR_BUILD = 1'b0;
`endif

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          fifo_empty, fifo_full;
    logic          wr_txdata, wr_status, push, pop;
    logic          overflow;
    logic [2:0]    state;
    logic [BW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          baud_done, fsm_active;
    logic [7:0]    head;
    logic          unused_wdata;

    assign unused_wdata = ^wdata[31:8];

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_CNT);
    assign head       = mem[rd_ptr];
    assign wr_txdata  = sel & we & (addr == 4'h0);
    assign wr_status  = sel & we & (addr == 4'h4);
    assign baud_done  = (baud == BAUD_LAST);
    assign fsm_active = (state != IDLE);
    assign busy       = fsm_active | ~fifo_empty;

    // The serialiser pops when idle or at the very end of a stop bit, so frames chain without a gap.
    assign pop  = ~fifo_empty & ((state == IDLE) | ((state == STOP) & baud_done));
    assign push = wr_txdata & (~fifo_full | pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (wr_status && wdata[3]) begin
                overflow <= 1'b0;
            end else if (wr_txdata && !push) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    logic par;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            par <= 1'b0;
        end else if (pop) begin
            par <= ^head;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            tx      <= 1'b1;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        shift <= head;
                        tx    <= 1'b0;
                        baud  <= '0;
                        state <= START;
                    end
                end
                START: begin
                    if (baud_done) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        tx      <= shift[0];
                        state   <= DATA;
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx    <= par;
                            state <= PARITY;
`else
                            tx    <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            shift   <= {1'b0, shift[7:1]};
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shift[1];
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_done) begin
                        baud  <= '0;
                        tx    <= 1'b1;
                        state <= STOP;
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
`endif
                STOP: begin
                    if (baud_done) begin
                        baud <= '0;
                        if (pop) begin
                            shift <= head;
                            tx    <= 1'b0;
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    baud  <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else if (sel && re) begin
            if (addr == 4'h4) begin
                rdata <= {27'b0, PAR_BUILD, overflow, fifo_empty, fifo_full, fsm_active};
            end else begin
                rdata <= '0;
            end
        end
    end
endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter (8N1) on the processor data-memory bus, downstream of the pipelined core inside the top-level board interface.
- Drives the board serial line RsTx.
- Core stores bytes to a TXDATA register; a small FIFO buffers them and a bit-serialiser shifts them out at a fixed baud.
- Core polls a STATUS register for flow control.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (115200 baud at 100 MHz); legal range >= 2.
- FIFO_DEPTH, 4, TX FIFO entries; power of 2, >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- sel  input  1  bus select, decoded upstream for this peripheral.
- we  input  1  write strobe, qualified by sel.
- re  input  1  read strobe, qualified by sel.
- addr  input  4  byte offset: 0x0 = TXDATA, 0x4 = STATUS.
- wdata  input  32  write data.
- rdata  output  32  read data, registered.
- tx  output  1  serial line to RsTx, idle high.
- busy  output  1  high while the FIFO is non-empty or a frame is in flight (LED use).

Behaviour:
- Reset (reset=0, asynchronous):
  - tx=1, rdata=0, busy=0.
  - FIFO flushed (count 0), FSM to IDLE.
  - Bit and baud counters 0, overflow flag 0.
- TXDATA write (sel&we&addr==0x0):
  - If the FIFO is not full, push wdata[7:0].
  - If full, the byte is dropped and the sticky overflow flag is set.
  - wdata[31:8] is ignored.
- STATUS write (sel&we&addr==0x4): wdata[3]=1 clears overflow; all other bits ignored.
- Reads (sel&re):
  - rdata is updated on the next rising edge (1-cycle latency) and holds until the next read.
  - STATUS = {28'b0, overflow, fifo_empty, fifo_full, fsm_active}, bits [3:0].
  - TXDATA reads return 0, as do unmapped offsets.
- Write and read in the same cycle are both serviced.
- FIFO rules:
  - Push and pop in the same cycle are both performed and count is unchanged, including when full.
  - Pop happens only when non-empty.
  - Pointers wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty, pop into the 8-bit shift register, drive tx<=0, clear the baud counter, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles, then shift right and increment the index. After bit 7 completes, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At its end, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Timing:
  - A write sampled at edge N into an empty FIFO with the FSM in IDLE gives tx low after edge N+1.
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
- The baud counter counts 0..CLKS_PER_BIT-1 and wraps; a bit boundary occurs when it reaches CLKS_PER_BIT-1.
- fsm_active = (state != IDLE). busy = fsm_active | ~fifo_empty.
- Reset asserted mid-frame: tx returns high immediately (asynchronous). The partial frame is abandoned and queued bytes are lost.
- tx is registered; it has no combinational path from the bus inputs.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- When defined:
  - A PARITY state sits between DATA and STOP.
  - tx = even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame length is 11*CLKS_PER_BIT.
  - STATUS bit 4 reads 1 (parity build indicator).
- When undefined: no PARITY state, STATUS bit 4 = 0, frame is 10*CLKS_PER_BIT.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
1. Hold reset low 5 cycles, release, read STATUS -> tx=1, busy=0, rdata=0x00000004 one cycle after the read.
2. Write 0xA5 to 0x0 at edge N -> tx low after N+1 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop high 4 cycles; busy falls after the 40-cycle frame.
3. Write 0x01, 0x02, 0x03 on consecutive cycles -> three contiguous frames, 120 cycles total, no idle-high gap between the stop bit and the next start bit.
4. Write 6 bytes on consecutive cycles starting from idle -> 5 accepted (1 popped plus 4 queued), 6th dropped; STATUS reads 0x0000000B (overflow, full, active); write 0x8 to 0x4 -> overflow clears; exactly 5 frames appear on tx.
5. Assert reset during DATA bit 3 of a frame with 2 bytes queued -> tx=1 in the same cycle; after release STATUS=0x00000004 and tx stays high for 100 cycles.
6. With UART_TX_PARITY_EN, write 0x07 -> parity bit 1 after data bit 7, frame 44 cycles, STATUS bit 4 = 1.
